// File: rtl/ir_emitter_ctrl.sv
// ir_emitter_ctrl: active IR presence detector. Emits modulated carrier bursts
// separated by dark gaps, samples the synchronised receiver at the end of each
// burst and each gap, and debounces per-frame hit/miss results into
// object_present.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high
//   enable         level; 1 = run burst/gap frames
//   ir_rx_n        raw demodulated receiver output, active-low, asynchronous
//   ir_led         LED drive, 1 = LED on
//   burst_active   1 while the FSM is in BURST
//   hit_pulse      one-clock strobe, frame evaluated as a hit
//   object_present debounced detection result
//
// Build option: define IR_AMBIENT_REJECT_EN to require a dark receiver at gap
// end as part of a hit. Without it, a hit depends on the burst sample only.
module ir_emitter_ctrl #(
  parameter int unsigned CLK_FREQ       = 50_000_000,
  parameter int unsigned CARRIER_HZ     = 38_000,
  parameter int unsigned BURST_CYCLES   = 20,
  parameter int unsigned GAP_CYCLES     = 60,
  parameter int unsigned HIT_THRESHOLD  = 3,
  parameter int unsigned MISS_THRESHOLD = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic ir_rx_n,
  output logic ir_led,
  output logic burst_active,
  output logic hit_pulse,
  output logic object_present
);

  localparam int unsigned HALF_PERIOD = CLK_FREQ / (2 * CARRIER_HZ);
  localparam int unsigned BURST_LEN   = 2 * BURST_CYCLES * HALF_PERIOD;
  localparam int unsigned GAP_LEN     = 2 * GAP_CYCLES * HALF_PERIOD;
  localparam int unsigned TW          = 32;
  localparam int unsigned CW          = 4;

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  state_t          state, state_d;
  logic [TW-1:0]   timer, timer_d;
  logic [TW-1:0]   phase, phase_d;
  logic [CW-1:0]   hit_cnt, hit_cnt_d;
  logic [CW-1:0]   miss_cnt, miss_cnt_d;
  logic            burst_seen, burst_seen_d;
  logic            led_d, burst_active_d, hit_pulse_d, object_present_d;
  logic            rx_meta, rx_s;
  logic            frame_hit_c;

  // Frame verdict, meaningful only on the last GAP clock.
`ifdef IR_AMBIENT_REJECT_EN
  assign frame_hit_c = burst_seen & rx_s;
`else
  assign frame_hit_c = burst_seen;
`endif

  // State, timers, counters, synchroniser and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      timer          <= '0;
      phase          <= '0;
      hit_cnt        <= '0;
      miss_cnt       <= '0;
      burst_seen     <= 1'b0;
      ir_led         <= 1'b0;
      burst_active   <= 1'b0;
      hit_pulse      <= 1'b0;
      object_present <= 1'b0;
      rx_meta        <= 1'b1;
      rx_s           <= 1'b1;
    end else begin
      state          <= state_d;
      timer          <= timer_d;
      phase          <= phase_d;
      hit_cnt        <= hit_cnt_d;
      miss_cnt       <= miss_cnt_d;
      burst_seen     <= burst_seen_d;
      ir_led         <= led_d;
      burst_active   <= burst_active_d;
      hit_pulse      <= hit_pulse_d;
      object_present <= object_present_d;
      rx_meta        <= ir_rx_n;
      rx_s           <= rx_meta;
    end
  end

  // Next-state and next-output logic; outputs are the values for the next clock.
  always_comb begin
    state_d          = state;
    timer_d          = timer;
    phase_d          = phase;
    hit_cnt_d        = hit_cnt;
    miss_cnt_d       = miss_cnt;
    burst_seen_d     = burst_seen;
    led_d            = 1'b0;
    burst_active_d   = 1'b0;
    hit_pulse_d      = 1'b0;
    object_present_d = object_present;

    case (state)
      IDLE: begin
        if (enable) begin
          state_d        = BURST;
          timer_d        = TW'(BURST_LEN - 1);
          phase_d        = TW'(HALF_PERIOD - 1);
          led_d          = 1'b1;
          burst_active_d = 1'b1;
        end
      end

      BURST: begin
        if (!enable) begin
          state_d          = IDLE;
          timer_d          = '0;
          phase_d          = '0;
          hit_cnt_d        = '0;
          miss_cnt_d       = '0;
          burst_seen_d     = 1'b0;
          object_present_d = 1'b0;
        end else if (timer == '0) begin
          burst_seen_d = ~rx_s;
          state_d      = GAP;
          timer_d      = TW'(GAP_LEN - 1);
          phase_d      = '0;
        end else begin
          timer_d        = timer - TW'(1);
          burst_active_d = 1'b1;
          // Carrier toggles each time the half-period counter expires.
          if (phase == '0) begin
            led_d   = ~ir_led;
            phase_d = TW'(HALF_PERIOD - 1);
          end else begin
            led_d   = ir_led;
            phase_d = phase - TW'(1);
          end
        end
      end

      GAP: begin
        if (timer == '0) begin
          // A completed frame is always evaluated, even if enable just fell.
          if (frame_hit_c) begin
            hit_pulse_d = 1'b1;
            miss_cnt_d  = '0;
            if (hit_cnt < CW'(HIT_THRESHOLD)) hit_cnt_d = hit_cnt + CW'(1);
            if (hit_cnt_d == CW'(HIT_THRESHOLD)) object_present_d = 1'b1;
          end else begin
            hit_cnt_d = '0;
            if (miss_cnt < CW'(MISS_THRESHOLD)) miss_cnt_d = miss_cnt + CW'(1);
            if (miss_cnt_d == CW'(MISS_THRESHOLD)) object_present_d = 1'b0;
          end
          burst_seen_d = 1'b0;
          if (enable) begin
            state_d        = BURST;
            timer_d        = TW'(BURST_LEN - 1);
            phase_d        = TW'(HALF_PERIOD - 1);
            led_d          = 1'b1;
            burst_active_d = 1'b1;
          end else begin
            state_d = IDLE;
            timer_d = '0;
          end
        end else if (!enable) begin
          state_d          = IDLE;
          timer_d          = '0;
          phase_d          = '0;
          hit_cnt_d        = '0;
          miss_cnt_d       = '0;
          burst_seen_d     = 1'b0;
          object_present_d = 1'b0;
        end else begin
          timer_d = timer - TW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = '0;
        phase_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ir_emitter_ctrl.sv
// Testbench for ir_emitter_ctrl using the small test configuration
// (HALF_PERIOD=5, 20-clock burst, 30-clock gap, 50-clock frame).
module tb_ir_emitter_ctrl;

  localparam int HIT_T   = 3;
  localparam int MISS_T  = 2;
  localparam int BURST_L = 20;
  localparam int FRAME_L = 50;
  localparam int HALF_P  = 5;

  logic clk, reset, enable, ir_rx_n;
  logic ir_led, burst_active, hit_pulse, object_present;

  ir_emitter_ctrl #(
    .CLK_FREQ(1000), .CARRIER_HZ(100), .BURST_CYCLES(2), .GAP_CYCLES(3),
    .HIT_THRESHOLD(HIT_T), .MISS_THRESHOLD(MISS_T)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .ir_rx_n(ir_rx_n),
    .ir_led(ir_led), .burst_active(burst_active),
    .hit_pulse(hit_pulse), .object_present(object_present)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: frame position and frame-level debounce state.
  int   k = -1;          // position within frame of the current clock, -1 = idle
  int   hcnt = 0, mcnt = 0;
  logic obj = 1'b0;
  logic exp_hit = 1'b0;
  logic burst_rx = 1'b1, gap_rx = 1'b1;
  int   bmode = 1, gmode = 1;  // 0 drive 0, 1 drive 1, 2 random

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s k=%0d observed=%0b expected=%0b", tag, k, obs, exp);
  endtask

  function automatic logic pick(input int mode);
    if (mode == 2) return logic'($urandom_range(0, 1));
    return (mode == 1);
  endfunction

  task automatic eval_frame();
    logic seen, hit;
    seen = (burst_rx == 1'b0);
`ifdef IR_AMBIENT_REJECT_EN
    hit = seen && (gap_rx == 1'b1);
`else
    hit = seen;
`endif
    if (hit) begin
      exp_hit = 1'b1;
      mcnt = 0;
      if (hcnt < HIT_T) hcnt++;
      if (hcnt == HIT_T) obj = 1'b1;
    end else begin
      hcnt = 0;
      if (mcnt < MISS_T) mcnt++;
      if (mcnt == MISS_T) obj = 1'b0;
    end
  endtask

  task automatic check_outputs();
    logic led_e, ba_e;
    ba_e  = (k >= 0) && (k < BURST_L);
    led_e = ba_e && (((k / HALF_P) % 2) == 0);
    chk("ir_led", ir_led, led_e);
    chk("burst_active", burst_active, ba_e);
    chk("hit_pulse", hit_pulse, exp_hit);
    chk("object_present", object_present, obj);
  endtask

  // One clock: advance model, check outputs, then drive receiver for the frame.
  task automatic cycle();
    logic e;
    e = enable;
    @(posedge clk);
    #1;
    exp_hit = 1'b0;
    if (k < 0) begin
      k = e ? 0 : -1;
    end else if (k == FRAME_L - 1) begin
      eval_frame();
      k = e ? 0 : -1;
    end else if (!e) begin
      k = -1; hcnt = 0; mcnt = 0; obj = 1'b0;
    end else begin
      k++;
    end
    check_outputs();
    if (k == BURST_L - 1) burst_rx = ir_rx_n;
    if (k == FRAME_L - 1) gap_rx = ir_rx_n;
    if (k == 0) ir_rx_n = pick(bmode);
    if (k == BURST_L) ir_rx_n = pick(gmode);
  endtask

  task automatic run_frames(input int n, input int bm, input int gm);
    bmode = bm; gmode = gm;
    for (int i = 0; i < n * FRAME_L; i++) cycle();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; ir_rx_n = 1'b1;
    #1;
    check_outputs();
    #20;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // Carrier shape with no reflection.
    enable = 1'b1;
    run_frames(2, 1, 1);
    // Reflection in burst, clear gap: detection after three hits.
    run_frames(4, 0, 1);
    // Target lost.
    run_frames(3, 1, 1);
    // Receiver stuck low.
    run_frames(5, 0, 0);
    run_frames(3, 1, 1);

    // Abort on clock 12 of a burst, then restart.
    run_frames(3, 0, 1);
    while (k != 0) cycle();
    while (k != 11) cycle();
    enable = 1'b0;
    cycle();
    for (int i = 0; i < 4; i++) cycle();
    enable = 1'b1;
    run_frames(4, 0, 1);

    // Asynchronous reset mid-gap with object present.
    while (k != 30) cycle();
    chk("obj_before_reset", object_present, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    k = -1; hcnt = 0; mcnt = 0; obj = 1'b0; exp_hit = 1'b0;
    check_outputs();
    enable = 1'b0;
    ir_rx_n = 1'b1;
    #10;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) cycle();
    enable = 1'b1;
    run_frames(3, 0, 1);
    cycle();

    // Random receiver activity across frames.
    run_frames(12, 2, 2);
    run_frames(6, 0, 2);
    cycle();
    enable = 1'b0;
    for (int i = 0; i < 60; i++) cycle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ir_emitter_ctrl.md
Name: ir_emitter_ctrl

Overview:
Active IR transmitter for the presence-detection path. It drives the IR LED with modulated carrier bursts separated by dark gaps. It samples the demodulating IR receiver at the end of each burst and each gap, and declares an object present only when the reflection follows its own bursts. It sits on the emitter side of the same IR link whose receiver output feeds the relay controller.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
CARRIER_HZ, 38_000, LED modulation frequency; HALF_PERIOD = CLK_FREQ/(2*CARRIER_HZ), integer truncation, must be >= 1
BURST_CYCLES, 20, carrier periods per burst
GAP_CYCLES, 60, carrier-period durations of LED-off gap after each burst
HIT_THRESHOLD, 3, consecutive hit frames needed to set object_present (1..15)
MISS_THRESHOLD, 3, consecutive miss frames needed to clear object_present (1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high
enable  input  1  level; 1 = run burst/gap frames
ir_rx_n  input  1  raw demodulated receiver output, active-low (0 = carrier seen); asynchronous
ir_led  output  1  LED drive, 1 = LED on
burst_active  output  1  1 while FSM is in BURST
hit_pulse  output  1  one-clock strobe, frame evaluated as a hit
object_present  output  1  debounced detection result

Behaviour:
- Reset values: ir_led=0, burst_active=0, hit_pulse=0, object_present=0, FSM=IDLE, all counters 0, both synchroniser flops=1.
- ir_rx_n passes through a 2-flop synchroniser (rx_s). All sampling uses rx_s.
- FSM states: IDLE, BURST, GAP.
- IDLE: LED 0. enable=1 moves to BURST on the next edge.
- BURST lasts exactly 2*BURST_CYCLES*HALF_PERIOD clocks.
  - ir_led=1 on the first BURST clock and toggles every HALF_PERIOD clocks.
  - burst_active=1 throughout.
  - On the last BURST clock, latch burst_seen = ~rx_s. Then go to GAP.
- GAP lasts exactly 2*GAP_CYCLES*HALF_PERIOD clocks, with ir_led=0.
  - On the last GAP clock, evaluate the frame: hit = burst_seen & rx_s (gap must be clear).
  - Next state is BURST if enable=1, else IDLE.
- Frame evaluation, registered on the edge ending the last GAP clock:
  - hit: hit_pulse=1 for exactly one clock; hit_cnt increments, saturating at HIT_THRESHOLD; miss_cnt clears.
  - miss: miss_cnt increments, saturating at MISS_THRESHOLD; hit_cnt clears.
  - object_present sets in the same cycle hit_cnt reaches HIT_THRESHOLD.
  - object_present clears in the same cycle miss_cnt reaches MISS_THRESHOLD.
  - Otherwise object_present holds.
- enable deasserted mid-BURST or mid-GAP: on the next edge the FSM goes to IDLE.
  - ir_led=0, burst_active=0.
  - Timers, hit_cnt, miss_cnt and burst_seen clear.
  - object_present clears to 0; no hit_pulse is generated.
- enable reasserted in IDLE: a fresh frame starts. Partial frames are never evaluated.
- Timers are 32-bit and count down to 0; there is no wrap-around.
- Reset mid-frame returns all state to its reset values immediately (asynchronous).
- Frame period is 2*(BURST_CYCLES+GAP_CYCLES)*HALF_PERIOD clocks. There is no idle clock between consecutive frames while enable=1.

Optional Feature:
IR_AMBIENT_REJECT_EN
- Defined: hit = burst_seen & rx_s at gap end, as above. A receiver that is stuck low or sees ambient IR is rejected, because the gap check fails.
- Undefined: hit = burst_seen only. The gap sample is ignored, which is allowed for lab setups with no ambient IR. All other timing is identical.

Test Plan:
All scenarios use CLK_FREQ=1000, CARRIER_HZ=100 (HALF_PERIOD=5), BURST_CYCLES=2, GAP_CYCLES=3, HIT_THRESHOLD=3, MISS_THRESHOLD=2.
1. Carrier shape: reset released, enable=1, ir_rx_n=1 -> ir_led pattern 5 high / 5 low / 5 high / 5 low, then 30 clocks low; burst_active high for exactly 20 clocks; frame period 50 clocks; no hit_pulse.
2. Reflection: ir_rx_n=0 during every BURST and 1 during GAP -> hit_pulse once per frame; object_present rises after the 3rd frame's evaluation, not after the 2nd.
3. Loss of target: after scenario 2, ir_rx_n held 1 -> object_present falls at the 2nd miss evaluation; hit_pulse stays 0.
4. Ambient rejection: ir_rx_n held 0 continuously.
   - With IR_AMBIENT_REJECT_EN: no hit_pulse; object_present stays 0 over 5 frames.
   - Without the macro: object_present sets after 3 frames.
5. Abort: enable dropped on clock 12 of a BURST -> next edge ir_led=0, burst_active=0, object_present=0, no hit_pulse; re-enable -> full 20-clock burst restarts.
6. Async reset asserted mid-GAP with object_present=1 -> all outputs 0 without waiting for a clock edge; after release plus enable, 3 fresh hit frames are needed to set object_present.
